// File: rtl/pipe_pkg.sv
// Shared constants for the F->D pipeline boundary of the MIPS core.
//   ST_*             : encoding of the instruction re-timing state
//   EXC_NONE         : exception code meaning "no exception"
//   DEF_*            : default reset PC, exception handler entry, bubble word
package pipe_pkg;

    localparam logic [1:0] ST_NORMAL = 2'd0;  // D shows the live IM read data
    localparam logic [1:0] ST_HELD   = 2'd1;  // D shows the captured instruction
    localparam logic [1:0] ST_SQUASH = 2'd2;  // D shows a bubble

    localparam int unsigned EXC_NONE = 0;

    localparam logic [31:0] DEF_RESET_PC     = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC   = 32'h0000_4180;
    localparam logic [31:0] DEF_BUBBLE_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_hold_buf.sv
// Re-times the synchronous-read instruction memory output for the D stage.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   stall_i         : hold D contents
//   flush_i         : exception entry, ERET or D kill this cycle
//   exc_nonzero_i   : instruction in D carries an exception
//   instr_i         : IM read data for the PC registered last edge
//   instr_o         : instruction presented to D (combinational)
module instr_hold_buf
    import pipe_pkg::*;
#(
    parameter int unsigned          INSTR_W      = 32,
    parameter logic [INSTR_W-1:0]   BUBBLE_INSTR = INSTR_W'(DEF_BUBBLE_INSTR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               exc_nonzero_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [INSTR_W-1:0] instr_o
);

    logic [1:0]         state_q, state_d;
    logic [INSTR_W-1:0] hold_q;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_SQUASH;
        end else if (!stall_i) begin
            state_d = ST_NORMAL;
        end else if (state_q == ST_NORMAL) begin
            // First stalled edge: the live IM data is about to go stale.
            state_d = ST_HELD;
        end
    end

    always_comb begin
        if (state_q == ST_SQUASH || exc_nonzero_i) begin
            instr_o = BUBBLE_INSTR;
        end else if (state_q == ST_HELD) begin
            instr_o = hold_q;
        end else begin
            instr_o = instr_i;
        end
    end

    // Capturing the visible word every edge means HELD re-captures itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SQUASH;
            hold_q  <= BUBBLE_INSTR;
        end else begin
            state_q <= state_d;
            hold_q  <= instr_o;
        end
    end

endmodule

// File: rtl/if_id_stage_reg.sv
// F->D pipeline boundary register with CP0 exception support.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   stall               : hold D contents
//   exc_req / eret      : exception entry / ERET commit (flush D)
//   epc                 : ERET return PC
//   kill_d              : squash only the instruction entering D
//   in_pc/in_exc/in_is_cf/in_instr : F-stage values and IM read data
//   out_pc/out_exc/out_bd/out_valid/out_instr : D-stage values
//   stall_cnt           : saturating count of stalled edges
module if_id_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          PC_W         = 32,
    parameter int unsigned          INSTR_W      = 32,
    parameter int unsigned          EXC_W        = 5,
    parameter logic [PC_W-1:0]      RESET_PC     = PC_W'(DEF_RESET_PC),
    parameter logic [PC_W-1:0]      HANDLER_PC   = PC_W'(DEF_HANDLER_PC),
    parameter logic [INSTR_W-1:0]   BUBBLE_INSTR = INSTR_W'(DEF_BUBBLE_INSTR),
    parameter int unsigned          CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               exc_req,
    input  logic               eret,
    input  logic [PC_W-1:0]    epc,
    input  logic               kill_d,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [EXC_W-1:0]   in_exc,
    input  logic               in_is_cf,
    input  logic [INSTR_W-1:0] in_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [EXC_W-1:0]   out_exc,
    output logic               out_bd,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [PC_W-1:0]  pc_q,  pc_d;
    logic [EXC_W-1:0] exc_q, exc_d;
    logic             bd_q,  bd_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush;

    assign flush = exc_req | eret | kill_d;

    always_comb begin
        pc_d    = pc_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (exc_req) begin
            pc_d    = HANDLER_PC;
            exc_d   = EXC_W'(EXC_NONE);
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (eret) begin
            pc_d    = epc;
            exc_d   = EXC_W'(EXC_NONE);
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (kill_d) begin
            pc_d    = in_pc;
            exc_d   = EXC_W'(EXC_NONE);
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = in_pc;
            exc_d   = in_exc;
            bd_d    = in_is_cf;
            valid_d = 1'b1;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            exc_q   <= EXC_W'(EXC_NONE);
            bd_q    <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    instr_hold_buf #(
        .INSTR_W      (INSTR_W),
        .BUBBLE_INSTR (BUBBLE_INSTR)
    ) u_hold (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall),
        .flush_i       (flush),
        .exc_nonzero_i (exc_q != EXC_W'(EXC_NONE)),
        .instr_i       (in_instr),
        .instr_o       (out_instr)
    );

    assign out_pc    = pc_q;
    assign out_exc   = exc_q;
    assign out_bd    = bd_q;
    assign out_valid = valid_q;
    assign stall_cnt = cnt_q;

endmodule
